// File: rtl/uart_receiver.sv
// uart_receiver -- serial-to-parallel UART receive path (start + data + stop,
// LSB first, default 8N1).
//
// The asynchronous line is double-flopped, a falling edge opens a frame, the
// start bit is re-checked half a bit later (this also aligns all further
// sampling to mid-bit), then each data bit and the stop bit are sampled one
// full bit period apart. A correctly framed word is latched into Data_Out and
// flagged with the sticky Rx_Flag until Clear_Flag acknowledges it.
//
// Optional feature, macro UART_RX_PARITY_EN:
//   adds an even-parity bit between the data bits and the stop bit, plus the
//   Parity_Error output. Without the macro the frame is start+data+stop.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-low reset
//   Serial_In     asynchronous serial line, idles high
//   Clear_Flag    one-cycle acknowledge, clears Rx_Flag and Overrun
//   Data_Out      last correctly framed word
//   Rx_Flag       sticky "new word on Data_Out"
//   Framing_Error stop bit of the last frame sampled 0 (not sticky)
//   Overrun       sticky, a word completed while Rx_Flag was still set
//   Busy          receiver is inside a frame (any state but IDLE)
//   Parity_Error  (UART_RX_PARITY_EN only) parity of the last frame was odd
//
// WORD_LENGTH must be at least 2.

module uart_receiver #(
  parameter int WORD_LENGTH = 8,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Serial_In,
  input  logic                   Clear_Flag,
  output logic [WORD_LENGTH-1:0] Data_Out,
  output logic                   Rx_Flag,
  output logic                   Framing_Error,
  output logic                   Overrun,
`ifdef UART_RX_PARITY_EN
  output logic                   Parity_Error,
`endif
  output logic                   Busy
);

  localparam int CLKS_RAW     = CLK_FREQ / BAUD_RATE;
  // Below 4 clocks per bit the half-bit start check has no room to work.
  localparam int CLKS_PER_BIT = (CLKS_RAW < 4) ? 4 : CLKS_RAW;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Two-flop synchroniser; both stages reset to the idle (high) level so a
  // reset release never looks like a start edge.
  logic sync1_q;
  logic rx_s_q;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   flag_q, flag_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   word_done;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   pe_q, pe_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= Serial_In;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    fe_d      = fe_q;
    word_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    pe_d      = pe_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) state_d = ST_START;
      end

      ST_START: begin
        // Still low half a bit later: genuine start bit; otherwise a glitch.
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // LSB arrives first, so shift in from the top and move right.
          shift_d = {rx_s_q, shift_q[WORD_LENGTH-1:1]};
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bit_d = rx_s_q;
          state_d   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // Leave at stop-bit mid-point so a back-to-back start edge is seen.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          fe_d    = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
          pe_d    = (^shift_q) ^ par_bit_q;
`endif
          if (rx_s_q) begin
            word_done = 1'b1;
            data_d    = shift_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Bit-period counter: restarts on every state change and wraps each bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == ST_IDLE || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  // A completing word beats a simultaneous acknowledge.
  always_comb begin
    flag_d = flag_q;
    ovr_d  = ovr_q;
    if (Clear_Flag) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (word_done) begin
      flag_d = 1'b1;
      if (flag_q && !Clear_Flag) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign Data_Out      = data_q;
  assign Rx_Flag       = flag_q;
  assign Framing_Error = fe_q;
  assign Overrun       = ovr_q;
  assign Busy          = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Error  = pe_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- self-checking bench for uart_receiver at 16 clocks per
// bit. Frames are driven bit by bit on Serial_In; expected outputs come from a
// frame-level model (last good word, sticky flag, overrun, framing/parity).

module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Serial_In = 1'b1;
  logic       Clear_Flag = 1'b0;
  logic [7:0] Data_Out;
  logic       Rx_Flag;
  logic       Framing_Error;
  logic       Overrun;
  logic       Busy;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Error;
`endif

  int total = 0;
  int bad = 0;

  // Frame-level reference model.
  logic [7:0] m_data = 8'h00;
  logic       m_flag = 1'b0;
  logic       m_fe   = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_pe   = 1'b0;

  uart_receiver #(
    .WORD_LENGTH(8),
    .CLK_FREQ(160),
    .BAUD_RATE(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Serial_In(Serial_In),
    .Clear_Flag(Clear_Flag),
    .Data_Out(Data_Out),
    .Rx_Flag(Rx_Flag),
    .Framing_Error(Framing_Error),
    .Overrun(Overrun),
`ifdef UART_RX_PARITY_EN
    .Parity_Error(Parity_Error),
`endif
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data"}, 32'(Data_Out), 32'(m_data));
    chk({tag, ".flag"}, 32'(Rx_Flag), 32'(m_flag));
    chk({tag, ".ferr"}, 32'(Framing_Error), 32'(m_fe));
    chk({tag, ".ovr"},  32'(Overrun), 32'(m_ovr));
    chk({tag, ".busy"}, 32'(Busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    chk({tag, ".perr"}, 32'(Parity_Error), 32'(m_pe));
`endif
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_flag = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    m_pe   = 1'b0;
  endtask

  // Applies one received frame to the model; clr_same means Clear_Flag was
  // pulsed in the very cycle the word completes.
  task automatic model_frame(input logic [7:0] d, input logic stop_b,
                             input logic par_b, input logic clr_same);
    m_fe = ~stop_b;
    m_pe = (^d) ^ par_b;
    if (clr_same) begin
      m_flag = 1'b0;
      m_ovr  = 1'b0;
    end
    if (stop_b) begin
      if (m_flag) m_ovr = 1'b1;
      m_flag = 1'b1;
      m_data = d;
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_pulse();
    Clear_Flag = 1'b1;
    @(negedge clk);
    Clear_Flag = 1'b0;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    @(negedge clk);
  endtask

  // Drives a full frame from a negedge. The word completes 154 clocks after
  // the start edge (10 clocks into the stop bit, one more with parity bit
  // ahead of it); clr_same raises Clear_Flag for exactly that cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input logic clr_same);
    $display("rx frame data=0x%02h stop=%0d par=%0d clr_same=%0d", d, stop_b, par_b, clr_same);
    Serial_In = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Serial_In = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    Serial_In = par_b;
    repeat (CPB) @(negedge clk);
`endif
    Serial_In = stop_b;
    for (int i = 0; i < CPB; i++) begin
      Clear_Flag = clr_same && (i == 10);
      @(negedge clk);
    end
    Clear_Flag = 1'b0;
    Serial_In  = 1'b1;
    model_frame(d, stop_b, par_b, clr_same);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    logic       clr_same;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame, then acknowledge.
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0);
    settle();
    check_outputs("f55");
    clear_pulse();
    check_outputs("f55_clr");

    // Short low glitch on an idle line.
    Serial_In = 1'b0;
    repeat (5) @(negedge clk);
    Serial_In = 1'b1;
    chk("glitch.busy_hi", 32'(Busy), 32'd1);
    repeat (10) @(negedge clk);
    check_outputs("glitch");

    // Bad stop bit, then a good frame.
    send_frame(8'hA3, 1'b0, ^8'hA3, 1'b0);
    settle();
    check_outputs("fA3_ferr");
    send_frame(8'h0F, 1'b1, ^8'h0F, 1'b0);
    settle();
    check_outputs("f0F");
    clear_pulse();

    // Back-to-back without acknowledge: overrun.
    send_frame(8'h12, 1'b1, ^8'h12, 1'b0);
    send_frame(8'h34, 1'b1, ^8'h34, 1'b0);
    settle();
    check_outputs("b2b_ovr");
    clear_pulse();

    // Back-to-back with acknowledge landing on the completion cycle.
    send_frame(8'h56, 1'b1, ^8'h56, 1'b0);
    send_frame(8'h78, 1'b1, ^8'h78, 1'b1);
    settle();
    check_outputs("b2b_clr");
    clear_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    settle();
    check_outputs("par_ok");
    clear_pulse();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    settle();
    check_outputs("par_bad");
    clear_pulse();
`endif

    // Randomised frames.
    for (int n = 0; n < 16; n++) begin
      d        = 8'($urandom);
      stop_b   = ($urandom_range(0, 3) != 0);
      par_b    = (^d) ^ ($urandom_range(0, 3) == 0);
      clr_same = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) clear_pulse();
      send_frame(d, stop_b, par_b, clr_same);
      repeat ($urandom_range(12, 30)) @(negedge clk);
      check_outputs($sformatf("rnd%0d", n));
    end

    // Mid-frame reset with a word already held.
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    settle();
    check_outputs("f3C");
    Serial_In = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      Serial_In = 1'($urandom);
      @(negedge clk);
    end
    chk("midframe.busy_hi", 32'(Busy), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    for (int i = 0; i < 8; i++) begin
      Serial_In = 1'($urandom);
      @(negedge clk);
    end
    Serial_In = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_outputs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
